// File: rtl/sync_pkg.sv
// sync_pkg: shared constants and sizing helpers for the synchronizer/debouncer.
package sync_pkg;
  localparam int MIN_STAGES = 2;
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles + 1);
  endfunction
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one channel of synchronizer chain, stability counter, debounced level and edge pulses.
module debounce_ch
  import sync_pkg::*;
#(
  parameter int   STAGES          = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_BIT       = 1'b0
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall,
  output logic o_accept
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_q;
  logic              r_rise;
  logic              r_fall;
  logic              w_s;
  logic              w_diff;
  logic              w_accept;
  assign w_s      = r_sync[STAGES-1];
  assign w_diff   = w_s != r_q;
  assign w_accept = w_diff && r_cnt == LAST;
  // Counter only runs while the synchronized level disagrees with q, so it never passes LAST.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sync <= {STAGES{RESET_BIT}};
      r_cnt  <= '0;
      r_q    <= RESET_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
      r_cnt  <= (w_diff && !w_accept) ? r_cnt + CW'(1) : '0;
      r_q    <= w_accept ? w_s : r_q;
      r_rise <= w_accept && w_s;
      r_fall <= w_accept && !w_s;
    end
  end
  assign o_q      = r_q;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;
  assign o_accept = w_accept;
endmodule

// File: rtl/sync_debounce.sv
// sync_debounce: WIDTH independent synchronize-and-debounce channels with registered edge pulses.
module sync_debounce
  import sync_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               STAGES          = 2,
  parameter int               DEBOUNCE_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL       = '0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_edge
);
  if (STAGES < MIN_STAGES) begin : g_bad_stages
    $error("sync_debounce: STAGES must be at least %0d", MIN_STAGES);
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_cycles
    $error("sync_debounce: DEBOUNCE_CYCLES must be at least 1");
  end
  logic [WIDTH-1:0] w_accept;
  logic             r_any_edge;
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    debounce_ch #(
      .STAGES         (STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_BIT      (RESET_VAL[i])
    ) u_ch (
      .Clk     (Clk),
      .Reset   (Reset),
      .i_d     (d[i]),
      .o_q     (q[i]),
      .o_rise  (rise[i]),
      .o_fall  (fall[i]),
      .o_accept(w_accept[i])
    );
  end
  // Registered from the channels' accept strobes so it lines up with rise/fall.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_any_edge <= 1'b0;
    else       r_any_edge <= |w_accept;
  end
  assign any_edge = r_any_edge;
endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: directed and randomized checks of sync_debounce against a history-based model.
module tb_sync_debounce;
  localparam int               W  = 4;
  localparam int               ST = 2;
  localparam int               DB = 4;
  localparam logic [W-1:0]     RV = 4'b0001;
  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] d = RV;
  logic [W-1:0] q, rise, fall;
  logic         any_edge;
  int n_cmp = 0;
  int n_bad = 0;
  sync_debounce #(.WIDTH(W), .STAGES(ST), .DEBOUNCE_CYCLES(DB), .RESET_VAL(RV)) dut (
    .Clk(Clk), .Reset(Reset), .d(d), .q(q), .rise(rise), .fall(fall), .any_edge(any_edge)
  );
  always #5 Clk = ~Clk;
  // Model: d samples ride a STAGES-deep delay; q flips once the last DB values it saw all disagree with it.
  logic [W-1:0] m_dh [ST];
  logic [W-1:0] m_sh [DB];
  logic [W-1:0] m_q, m_rise, m_fall, m_acc;
  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < ST; i++) m_dh[i] = RV;
      for (int i = 0; i < DB; i++) m_sh[i] = RV;
      m_q = RV;
      m_rise = '0;
      m_fall = '0;
    end else begin
      for (int i = DB - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
      m_sh[0] = m_dh[ST-1];
      m_acc = '1;
      for (int c = 0; c < W; c++)
        for (int j = 0; j < DB; j++)
          if (m_sh[j][c] == m_q[c]) m_acc[c] = 1'b0;
      m_rise = m_acc & ~m_q;
      m_fall = m_acc & m_q;
      m_q = m_q ^ m_acc;
      for (int i = ST - 1; i > 0; i--) m_dh[i] = m_dh[i-1];
      m_dh[0] = d;
    end
  end
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask
  always @(negedge Clk) begin
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_rise", 32'(rise), 32'(m_rise));
    chk("model_fall", 32'(fall), 32'(m_fall));
    chk("model_any", 32'(any_edge), 32'(|(m_rise | m_fall)));
  end
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask
  initial begin
    repeat (2) tick();
    chk("reset_q", 32'(q), 32'h1);
    chk("reset_pulses", 32'({rise, fall, any_edge}), 32'h0);
    Reset = 1'b0;
    repeat (3) tick();
    d[1] = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) chk("d1_rise_early", 32'(q[1]), 32'h0);
      if (k == 6) begin
        chk("d1_rise_q", 32'(q), 32'h3);
        chk("d1_rise_pulse", 32'(rise), 32'h2);
        chk("d1_rise_any", 32'(any_edge), 32'h1);
      end
      if (k == 7) chk("d1_rise_end", 32'(rise), 32'h0);
    end
    d[2] = 1'b1;
    repeat (3) tick();
    d[2] = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("glitch_q2", 32'(q[2]), 32'h0);
      chk("glitch_pulses", 32'({rise, fall}), 32'h0);
    end
    d[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) chk("d0_fall_early", 32'(q[0]), 32'h1);
      if (k == 6) begin
        chk("d0_fall_q", 32'(q), 32'h2);
        chk("d0_fall_pulse", 32'(fall), 32'h1);
      end
      if (k == 7) chk("d0_fall_end", 32'(fall), 32'h0);
    end
    d = 4'b0100;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 6) begin
        chk("simul_fall", 32'(fall), 32'h2);
        chk("simul_rise", 32'(rise), 32'h4);
        chk("simul_any", 32'(any_edge), 32'h1);
        chk("simul_q", 32'(q), 32'h4);
      end
      if (k == 7) chk("simul_any_end", 32'(any_edge), 32'h0);
    end
    d[3] = 1'b1;
    repeat (5) tick();
    #2 Reset = 1'b1;
    #1;
    chk("async_reset_q", 32'(q), 32'h1);
    chk("async_reset_pulses", 32'({rise, fall, any_edge}), 32'h0);
    tick();
    Reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("midcount_early", 32'(q), 32'h1);
      if (k == 6) begin
        chk("midcount_q", 32'(q), 32'hc);
        chk("midcount_rise", 32'(rise), 32'hc);
        chk("midcount_fall", 32'(fall), 32'h1);
      end
    end
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(5) == 0) d[c] = ~d[c];
      if ($urandom_range(399) == 0) begin
        #2 Reset = 1'b1;
        tick();
        Reset = 1'b0;
      end else begin
        tick();
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sync_debounce.md
SYNC_DEBOUNCE -- requirements
Module: sync_debounce

Interface
REQ-001 The module SHALL have parameter WIDTH, default 4: number of independent input channels.
REQ-002 The module SHALL have parameter STAGES, default 2: synchronizer flop depth per channel.
REQ-003 The module SHALL have parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles required to accept a change.
REQ-004 The module SHALL have parameter RESET_VAL, WIDTH bits, default all 0: per-channel reset level.
REQ-005 The module SHALL have port Clk, input, 1 bit: clock.
REQ-006 The module SHALL have port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 The module SHALL have port d, input, WIDTH bits: raw asynchronous inputs (switches/buttons).
REQ-008 The module SHALL have port q, output, WIDTH bits: synchronized, debounced level.
REQ-009 The module SHALL have port rise, output, WIDTH bits: one-cycle pulse per channel on accepted 0->1.
REQ-010 The module SHALL have port fall, output, WIDTH bits: one-cycle pulse per channel on accepted 1->0.
REQ-011 The module SHALL have port any_edge, output, 1 bit: OR of all rise and fall bits, same cycle.

Function
REQ-012 Each channel SHALL pass d[i] through a chain of STAGES flops; s[i] denotes the last stage output.
REQ-013 Each channel SHALL hold a counter of width $clog2(DEBOUNCE_CYCLES+1), cleared in any cycle where s[i]==q[i].
REQ-014 While s[i]!=q[i], the counter SHALL increment each cycle; when s[i]!=q[i] and the counter equals DEBOUNCE_CYCLES-1, q[i] SHALL take s[i] at the next edge and the counter SHALL clear.
REQ-015 A held change on d[i] SHALL appear on q[i] exactly STAGES+DEBOUNCE_CYCLES rising edges after the first edge that samples it; DEBOUNCE_CYCLES=1 means no filtering.
REQ-016 A pulse on s[i] shorter than DEBOUNCE_CYCLES cycles SHALL leave q[i] unchanged and produce no rise/fall.
REQ-017 rise[i] (fall[i]) SHALL be high for exactly the one cycle in which q[i] first shows 1 (0), and low otherwise.
REQ-018 All outputs SHALL be registered; channels SHALL be fully independent, with simultaneous transitions on several channels producing their pulses in the same cycle.
REQ-019 The counter SHALL never exceed DEBOUNCE_CYCLES-1 (no wrap-around).
REQ-020 Elaboration SHALL fail if STAGES<2 or DEBOUNCE_CYCLES<1.

Reset
REQ-021 Reset SHALL immediately, without waiting for Clk, force every sync stage and q[i] to RESET_VAL[i], all counters to 0, and rise, fall, and any_edge to 0.
REQ-022 No pulse SHALL be generated by reset assertion or release; a d/RESET_VAL mismatch after release SHALL be accepted only through the normal debounce path.
REQ-023 Reset asserted mid-count SHALL discard accumulated count.

Structure
REQ-024 Package sync_pkg SHALL hold the minimum-STAGES constant and a function computing the counter width.
REQ-025 A per-channel sub-module debounce_ch (sync chain, counter, q, rise, fall) SHALL be instantiated WIDTH times via generate; any_edge SHALL be formed at top level.

Verification (WIDTH=4, STAGES=2, DEBOUNCE_CYCLES=4, RESET_VAL=4'b0001)
REQ-026 Reset asserted between clock edges -> q=4'b0001, rise=fall=0, any_edge=0 before the next edge.
REQ-027 d[1] 0->1 held -> q[1]=1 exactly 6 edges after the first sampling edge; rise[1] and any_edge high that single cycle.
REQ-028 d[2] high for 3 cycles then low -> q[2] stays 0; rise/fall stay 0 throughout.
REQ-029 d[0] 1->0 held -> q[0]=0 after 6 edges; fall[0] one-cycle pulse.
REQ-030 d[3] high 3 cycles after synchronization, Reset pulsed, d[3] still high -> q[3]=1 only after a full 6 edges post-release.
REQ-031 d[1] falls and d[2] rises on the same edge (both stable) -> fall[1] and rise[2] in the same cycle; any_edge high one cycle.
